jpeg_bit_reader: RTL and testbench
==================================

JPEG_BIT_READER -- requirements
Module: jpeg_bit_reader

Interface
REQ-001 SHALL have parameter BUF_W, default 32, bit-buffer width; only the value 32 is supported.
REQ-002 SHALL have parameter WIN_W, default 16, peek-window width.
REQ-003 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port fifo_empty, input, 1, upstream show-ahead byte FIFO empty flag.
REQ-006 SHALL have port fifo_dout, input, 8, upstream FIFO head byte; valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_rd, output, 1, pop request; combinational; asserted only when fifo_empty=0.
REQ-008 SHALL have port win, output, 16, next 16 stream bits, MSB first (buf[31:16]).
REQ-009 SHALL have port win_valid, output, 1, win holds usable bits.
REQ-010 SHALL have port consume_en, input, 1, consumer discards bits this cycle.
REQ-011 SHALL have port consume_n, input, 5, bits to discard, 0..16.
REQ-012 SHALL have port flush, input, 1, discard all buffered bits (restart alignment).
REQ-013 SHALL have port marker_valid, output, 1, a marker was found and the block is stalled.
REQ-014 SHALL have port marker, output, 8, code byte following 0xFF.
REQ-015 SHALL have port marker_ack, input, 1, consumer releases the marker stall.

Function
REQ-016 SHALL hold a left-aligned bit buffer buf[31:0] and a count cnt[5:0] in the range 0..32.
REQ-017 SHALL have states DATA, FF_SEEN, MARKER.
REQ-018 SHALL pop one byte (fifo_rd=1) when fifo_empty=0, state≠MARKER, cnt≤24, flush=0.
REQ-019 SHALL, on a pop in DATA: byte≠0xFF -> append the byte; byte=0xFF -> append nothing, go to FF_SEEN.
REQ-020 SHALL, on a pop in FF_SEEN: byte=0x00 -> append 0xFF, go to DATA; byte=0xFF -> stay in FF_SEEN (fill byte); other -> marker<=byte, marker_valid<=1, go to MARKER.
REQ-021 SHALL, in MARKER, never pop; on marker_ack=1, clear marker_valid and go to DATA in the next cycle.
REQ-022 SHALL place an appended byte at buf bits [31-c -: 8], where c = cnt minus the bits consumed this cycle; cnt_next = cnt - n + 8.
REQ-023 SHALL, on consume, set buf <= buf << n and cnt -= n, in the same cycle as any append.
REQ-024 SHALL present a popped byte on win no earlier than, and exactly at, the cycle after the pop.
REQ-025 SHALL drive win_valid = (cnt≥16) | (state=MARKER & cnt>0); unfilled low bits of buf read as 0 (zero pad).
REQ-026 SHALL accept consume_en only when win_valid=1; a request of n>cnt is legal only in MARKER, and then saturates cnt to 0.
REQ-027 SHALL, on flush, clear buf and cnt to 0 and suppress pop and consume that cycle; state and marker are unaffected; flush has the highest priority.
REQ-028 SHALL, when consume and marker_ack occur together, apply both.

Reset
REQ-029 SHALL, on rst, set buf=0, cnt=0, state=DATA, marker=0, marker_valid=0, win_valid=0, fifo_rd=0; rst overrides all inputs.
REQ-030 SHALL make a mid-stream rst discard buffered bits and any pending marker; upstream FIFO reset is handled separately.

Structure
REQ-031 SHALL take from the shared package jpeg_pkg: state encoding, M_EOI=8'hD9, M_RST0..M_RST7=8'hD0..D7, BUF_W, WIN_W.
REQ-032 SHALL contain no sub-module; the shift/append logic is inline and it connects directly to the fifo_sync show-ahead output.

Verification
REQ-033 SHALL cover: bytes 12 34 56, consume 16 -> win=0x1234 one cycle after 2nd pop; then win=0x56xx after 3rd pop with cnt=8, win_valid=0.
REQ-034 SHALL cover: bytes FF 00 AB -> win=0xFFAB, two payload bytes, no marker.
REQ-035 SHALL cover: bytes 80 FF FF D9 -> after draining, marker=0xD9, marker_valid=1, no further fifo_rd, win=0x8000 with win_valid=1 (cnt=8); marker_ack -> back to DATA.
REQ-036 SHALL cover: cnt=24 with consume 4 and a pop in the same cycle -> cnt=28 and the byte lands at bit offset 20.
REQ-037 SHALL cover: flush while the FIFO is non-empty -> no pop that cycle, cnt=0, win_valid=0, and the next byte appears at buf[31:24].
REQ-038 SHALL cover: rst asserted in MARKER -> all outputs at reset values in the next cycle.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder definitions: bit-reader state encoding, marker codes and datapath widths.
package jpeg_pkg;

  localparam int unsigned BUF_W = 32;
  localparam int unsigned WIN_W = 16;

  localparam logic [7:0] M_EOI  = 8'hD9;
  localparam logic [7:0] M_RST0 = 8'hD0;
  localparam logic [7:0] M_RST1 = 8'hD1;
  localparam logic [7:0] M_RST2 = 8'hD2;
  localparam logic [7:0] M_RST3 = 8'hD3;
  localparam logic [7:0] M_RST4 = 8'hD4;
  localparam logic [7:0] M_RST5 = 8'hD5;
  localparam logic [7:0] M_RST6 = 8'hD6;
  localparam logic [7:0] M_RST7 = 8'hD7;

  typedef enum logic [1:0] {
    StData,
    StFfSeen,
    StMarker
  } state_e;

endpackage

// File: rtl/jpeg_bit_reader.sv
// JPEG entropy-segment bit reader: unstuffs 0xFF00, stalls on markers and presents a
// left-aligned 16-bit peek window over a 32-bit bit buffer fed from a show-ahead byte FIFO.
module jpeg_bit_reader #(
  parameter int unsigned BUF_W = jpeg_pkg::BUF_W,
  parameter int unsigned WIN_W = jpeg_pkg::WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd,
  output logic [WIN_W-1:0] win,
  output logic             win_valid,
  input  logic             consume_en,
  input  logic [4:0]       consume_n,
  input  logic             flush,
  output logic             marker_valid,
  output logic [7:0]       marker,
  input  logic             marker_ack
);
  import jpeg_pkg::*;

  localparam logic [5:0] FillMax = 6'(BUF_W - 8);
  localparam logic [5:0] WinCnt  = 6'(WIN_W);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] bits_q, bits_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       marker_q, marker_d;

  logic             consume;
  logic             append;
  logic [7:0]       app_byte;
  logic [5:0]       n_eff;
  logic [5:0]       cnt_left;

  assign win          = bits_q[BUF_W-1 -: WIN_W];
  assign win_valid    = (cnt_q >= WinCnt) | ((state_q == StMarker) & (cnt_q != 6'd0));
  assign marker_valid = (state_q == StMarker);
  assign marker       = marker_q;
  assign fifo_rd      = !rst && !fifo_empty && (state_q != StMarker) && (cnt_q <= FillMax)
                        && !flush;

  always_comb begin
    state_d  = state_q;
    marker_d = marker_q;
    append   = 1'b0;
    app_byte = fifo_dout;
    consume  = consume_en && win_valid && !flush;
    n_eff    = 6'd0;
    if (consume) begin
      // Over-long consumes (only legal while draining before a marker) saturate at empty.
      n_eff = ({1'b0, consume_n} > cnt_q) ? cnt_q : {1'b0, consume_n};
    end
    cnt_left = cnt_q - n_eff;

    if (fifo_rd) begin
      unique case (state_q)
        StData: begin
          if (fifo_dout == 8'hFF) state_d = StFfSeen;
          else                    append  = 1'b1;
        end
        StFfSeen: begin
          if (fifo_dout == 8'h00) begin
            append   = 1'b1;
            app_byte = 8'hFF;
            state_d  = StData;
          end else if (fifo_dout != 8'hFF) begin
            marker_d = fifo_dout;
            state_d  = StMarker;
          end
        end
        default: ;
      endcase
    end else if ((state_q == StMarker) && marker_ack) begin
      state_d = StData;
    end

    bits_d = bits_q << n_eff;
    cnt_d  = cnt_left;
    if (append) begin
      // Land the new byte directly below the bits that survive this cycle's consume.
      bits_d = bits_d | ({app_byte, {(BUF_W-8){1'b0}}} >> cnt_left);
      cnt_d  = cnt_left + 6'd8;
    end
    if (flush) begin
      bits_d = '0;
      cnt_d  = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StData;
      bits_q   <= '0;
      cnt_q    <= 6'd0;
      marker_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      bits_q   <= bits_d;
      cnt_q    <= cnt_d;
      marker_q <= marker_d;
    end
  end

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Directed bench for jpeg_bit_reader with a behavioural show-ahead byte FIFO upstream.
module tb_jpeg_bit_reader;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_rd;
  logic [15:0] win;
  logic        win_valid;
  logic        consume_en;
  logic [4:0]  consume_n;
  logic        flush;
  logic        marker_valid;
  logic [7:0]  marker;
  logic        marker_ack;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  logic [5:0] saved_ptr;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_rd) rd_ptr <= rd_ptr + 6'd1;
  end

  jpeg_bit_reader dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd      (fifo_rd),
    .win          (win),
    .win_valid    (win_valid),
    .consume_en   (consume_en),
    .consume_n    (consume_n),
    .flush        (flush),
    .marker_valid (marker_valid),
    .marker       (marker),
    .marker_ack   (marker_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; consume_en = 1'b0; consume_n = 5'd0; flush = 1'b0; marker_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win", {16'h0, win}, 32'h0);
    chk("rst_win_valid", {31'h0, win_valid}, 32'h0);
    chk("rst_marker_valid", {31'h0, marker_valid}, 32'h0);
    chk("rst_marker", {24'h0, marker}, 32'h0);
    chk("rst_fifo_rd", {31'h0, fifo_rd}, 32'h0);
    rst = 1'b0;
    cyc();

    // Plain bytes, then consume 16 while the third byte is popped.
    push(8'h12); push(8'h34); push(8'h56);
    #1;
    chk("s1_rd", {31'h0, fifo_rd}, 32'h1);
    cyc();
    chk("s1_win1", {16'h0, win}, 32'h1200);
    chk("s1_cnt1", {26'h0, dut.cnt_q}, 32'd8);
    chk("s1_wv1", {31'h0, win_valid}, 32'h0);
    cyc();
    chk("s1_win2", {16'h0, win}, 32'h1234);
    chk("s1_wv2", {31'h0, win_valid}, 32'h1);
    consume_en = 1'b1; consume_n = 5'd16;
    #1;
    chk("s1_rd3", {31'h0, fifo_rd}, 32'h1);
    cyc();
    consume_en = 1'b0;
    chk("s1_win3", {16'h0, win}, 32'h5600);
    chk("s1_cnt3", {26'h0, dut.cnt_q}, 32'd8);
    chk("s1_wv3", {31'h0, win_valid}, 32'h0);
    do_flush();

    // Byte stuffing: FF 00 is one payload 0xFF.
    push(8'hFF); push(8'h00); push(8'hAB);
    cyc();
    chk("s2_cnt_ff", {26'h0, dut.cnt_q}, 32'd0);
    cyc();
    chk("s2_win_ff00", {16'h0, win}, 32'hFF00);
    cyc();
    chk("s2_win", {16'h0, win}, 32'hFFAB);
    chk("s2_wv", {31'h0, win_valid}, 32'h1);
    chk("s2_cnt", {26'h0, dut.cnt_q}, 32'd16);
    chk("s2_mv", {31'h0, marker_valid}, 32'h0);
    do_flush();

    // Fill byte then EOI marker: stall, drain, ack together with saturating consume.
    push(8'h80); push(8'hFF); push(8'hFF); push(8'hD9);
    cyc();
    chk("s3_win80", {16'h0, win}, 32'h8000);
    cyc(); cyc(); cyc();
    chk("s3_mv", {31'h0, marker_valid}, 32'h1);
    chk("s3_marker", {24'h0, marker}, 32'hD9);
    chk("s3_win", {16'h0, win}, 32'h8000);
    chk("s3_wv", {31'h0, win_valid}, 32'h1);
    chk("s3_cnt", {26'h0, dut.cnt_q}, 32'd8);
    push(8'h11);
    #1;
    chk("s3_no_rd", {31'h0, fifo_rd}, 32'h0);
    cyc();
    chk("s3_no_rd2", {31'h0, fifo_rd}, 32'h0);
    chk("s3_mv_hold", {31'h0, marker_valid}, 32'h1);
    marker_ack = 1'b1; consume_en = 1'b1; consume_n = 5'd16;
    #1;
    chk("s3_no_rd_ack", {31'h0, fifo_rd}, 32'h0);
    cyc();
    marker_ack = 1'b0; consume_en = 1'b0;
    #1;
    chk("s3_mv_clr", {31'h0, marker_valid}, 32'h0);
    chk("s3_cnt_sat", {26'h0, dut.cnt_q}, 32'd0);
    chk("s3_wv_clr", {31'h0, win_valid}, 32'h0);
    chk("s3_rd_resume", {31'h0, fifo_rd}, 32'h1);
    cyc();
    chk("s3_win_after", {16'h0, win}, 32'h1100);
    do_flush();

    // Consume 4 at cnt=24 in the same cycle as a pop.
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    cyc(); cyc(); cyc();
    chk("s4_bits24", dut.bits_q, 32'hAABBCC00);
    chk("s4_rd24", {31'h0, fifo_rd}, 32'h1);
    consume_en = 1'b1; consume_n = 5'd4;
    cyc();
    consume_en = 1'b0;
    chk("s4_bits", dut.bits_q, 32'hABBCCDD0);
    chk("s4_cnt", {26'h0, dut.cnt_q}, 32'd28);
    chk("s4_win", {16'h0, win}, 32'hABBC);
    do_flush();

    // Flush with data waiting: no pop, buffer empties, next byte realigns to the top.
    push(8'h77);
    cyc();
    chk("s5_cnt_pre", {26'h0, dut.cnt_q}, 32'd8);
    push(8'h5A); push(8'hC3);
    flush = 1'b1;
    #1;
    chk("s5_no_rd", {31'h0, fifo_rd}, 32'h0);
    saved_ptr = rd_ptr;
    cyc();
    flush = 1'b0;
    chk("s5_no_pop", {26'h0, rd_ptr}, {26'h0, saved_ptr});
    chk("s5_cnt", {26'h0, dut.cnt_q}, 32'd0);
    chk("s5_wv", {31'h0, win_valid}, 32'h0);
    cyc();
    chk("s5_bits", dut.bits_q, 32'h5A000000);
    cyc();
    chk("s5_win", {16'h0, win}, 32'h5AC3);
    do_flush();

    // Reset while stalled on a marker.
    push(8'h42); push(8'hFF); push(8'hD0);
    cyc(); cyc(); cyc();
    chk("s6_mv", {31'h0, marker_valid}, 32'h1);
    chk("s6_marker", {24'h0, marker}, 32'hD0);
    push(8'h99);
    rst = 1'b1; consume_en = 1'b1; consume_n = 5'd8;
    #1;
    chk("s6_rd_in_rst", {31'h0, fifo_rd}, 32'h0);
    cyc();
    chk("s6_win", {16'h0, win}, 32'h0);
    chk("s6_wv", {31'h0, win_valid}, 32'h0);
    chk("s6_mv_clr", {31'h0, marker_valid}, 32'h0);
    chk("s6_marker_clr", {24'h0, marker}, 32'h0);
    chk("s6_rd", {31'h0, fifo_rd}, 32'h0);
    chk("s6_cnt", {26'h0, dut.cnt_q}, 32'd0);
    rst = 1'b0; consume_en = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
